// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage and the iterative divider div_seq.
// EX drives operands and start_i; the divider returns result_o, ready_o, busy_o and its FSM state.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    // Handshake: EX raises start_i with stable operands and keeps it high until it sees
    // ready_o; the divider captures the operands only on the FREE->ON/BYZERO transition.
    // result_o is valid whenever ready_o is high. Dropping start_i, or raising annul_i,
    // releases the divider, which returns to FREE on the next cycle.
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic [1:0]           state_dbg;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, state_dbg
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, state_dbg
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up on exit.
// Optional macro DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    div_seq_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     dvs_q;
    logic [WIDTH-1:0]     dvd_raw_q;
    logic                 sgn_q;
    logic                 dvd_neg_q;
    logic                 dvs_neg_q;
    logic                 early_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 ready_q;

    // Operand conditioning in FREE
    logic                 accept;
    logic                 dvd_neg;
    logic                 dvs_neg;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 early;

    // One restoring step
    logic [WIDTH:0]       shift_rem;
    logic [WIDTH:0]       trial;
    logic                 trial_ok;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quo_nx;
    logic                 last_iter;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    logic [2*WIDTH-1:0]   result_nx;
    logic                 ready_nx;

    always_comb begin
        accept  = bus.start_i && !bus.annul_i;
        dvd_neg = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
        dvs_neg = bus.signed_div_i && bus.opdata2_i[WIDTH-1];
        mag1    = dvd_neg ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
        mag2    = dvs_neg ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;
`ifdef DIV_EARLY_OUT_EN
        early   = (mag1 < mag2);
`else
        early   = 1'b0;
`endif
    end

    // The partial remainder stays below the divisor, so the shifted value needs one extra
    // bit and the trial difference fits in WIDTH+1 bits with its MSB acting as the sign.
    always_comb begin
        shift_rem = {rem_q, quo_q[WIDTH-1]};
        trial     = shift_rem - {1'b0, dvs_q};
        trial_ok  = !trial[WIDTH];
        rem_nx    = trial_ok ? trial[WIDTH-1:0] : shift_rem[WIDTH-1:0];
        quo_nx    = {quo_q[WIDTH-2:0], trial_ok};
        last_iter = (cnt == CW'(WIDTH - 1));
        quo_fix   = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? (~quo_nx + WIDTH'(1)) : quo_nx;
        rem_fix   = (sgn_q && dvd_neg_q) ? (~rem_nx + WIDTH'(1)) : rem_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FREE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        result_nx = result_q;
        case (state)
            S_FREE: begin
                if (accept) begin
                    state_nx = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                state_nx = bus.annul_i ? S_FREE : S_END;
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_nx = S_FREE;
                end else if (early_q || last_iter) begin
                    state_nx = S_END;
                end
            end
            S_END: begin
                if (!bus.start_i || bus.annul_i) begin
                    state_nx = S_FREE;
                end
            end
            default: state_nx = S_FREE;
        endcase

        // The result register only loads on entry to END; it holds through END and FREE.
        if (state == S_BYZERO && state_nx == S_END) begin
            result_nx = {dvd_raw_q, {WIDTH{1'b1}}};
        end else if (state == S_ON && state_nx == S_END) begin
            result_nx = early_q ? {dvd_raw_q, {WIDTH{1'b0}}} : {rem_fix, quo_fix};
        end
        ready_nx = (state_nx == S_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_raw_q <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            early_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            result_q <= result_nx;
            ready_q  <= ready_nx;
            if (state == S_FREE && accept) begin
                cnt       <= '0;
                rem_q     <= '0;
                quo_q     <= mag1;
                dvs_q     <= mag2;
                dvd_raw_q <= bus.opdata1_i;
                sgn_q     <= bus.signed_div_i;
                dvd_neg_q <= dvd_neg;
                dvs_neg_q <= dvs_neg;
                early_q   <= early;
            end else if (state == S_ON && !bus.annul_i) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign bus.result_o  = result_q;
    assign bus.ready_o   = ready_q;
    assign bus.busy_o    = (state != S_FREE);
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized operands against an
// arithmetic reference model; honours DIV_EARLY_OUT_EN for the expected latency.
module tb_div_seq;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_result = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer division in 64-bit arithmetic, truncated to W bits.
    function automatic logic [2*W-1:0] ref_div(input logic sg, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return {a, {W{1'b1}}};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    function automatic int exp_latency(input logic sg, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        longint ma, mb;
        if (b == '0) return 2;
        ma = sg ? longint'($signed(a)) : longint'(a);
        mb = sg ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`endif
        return W + 1;
    endfunction

    // ---------------- driver ----------------
    // Called at #1 after a rising edge with the divider in FREE.
    task automatic do_op(input string tag, input logic sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int extra_hold);
        int lat;
        logic [2*W-1:0] exp;
        lat = 0;
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        exp_q.push_back(ref_div(sg, a, b));
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            // Operands after acceptance must be ignored.
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = 1'($urandom_range(0, 1));
            if (k == 1) check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
            if (bus.ready_o) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_latency(sg, a, b)));
        exp = exp_q.pop_front();
        check({tag, "_res"}, bus.result_o, exp);
        last_result = exp;
        for (int j = 0; j < extra_hold; j++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
            check({tag, "_hold_res"}, bus.result_o, last_result);
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
        check({tag, "_drop_busy"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_drop_res"}, bus.result_o, last_result);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic saw_ready;
        logic sg;
        logic [W-1:0] a, b;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_result", bus.result_o, 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        do_op("u100_7",   1'b0, 32'd100, 32'd7, 2);
        do_op("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("s_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 1);
        do_op("divzero",  1'b0, 32'd5, 32'd0, 1);
        do_op("s_divzero",1'b1, 32'hFFFF_FF00, 32'd0, 0);
        do_op("s_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("s_3_10",   1'b1, 32'd3, 32'd10, 0);
        do_op("u_max",    1'b0, 32'hFFFF_FFFF, 32'd1, 0);

        // Annul mid-operation: busy drops, ready never rises, result untouched
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        saw_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            saw_ready |= bus.ready_o;
        end
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        check("annul_busy", 64'(bus.busy_o), 64'd0);
        check("annul_res", bus.result_o, last_result);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            saw_ready |= bus.ready_o;
        end
        check("annul_no_ready", 64'(saw_ready), 64'd0);
        do_op("after_annul", 1'b0, 32'd9, 32'd3, 0);

        // Asynchronous reset mid-ON
        do_op("pre_rst", 1'b0, 32'd12345, 32'd10, 0);
        bus.opdata1_i = 32'd77;
        bus.opdata2_i = 32'd5;
        bus.start_i   = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(bus.ready_o), 64'd0);
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_res", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: b = W'($urandom_range(1, 15));
                2: b = '0;
                3: begin a = W'($urandom_range(0, 50)); b = W'($urandom_range(51, 5000)); end
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF;
            endcase
            do_op($sformatf("rnd%0d", i), sg, a, b, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
